// File: rtl/serial_adder_if.sv
// Request/response bundle for the bit-serial adder: operands and start in,
// busy/done status and the registered result out.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell is fed LSB first from operand shift
// registers, with a carry flop closing the loop; WIDTH result bits in WIDTH cycles.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] sh_s_q, sh_s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_cout;

    fulladder u_fa (
        .A   (sh_a_q[0]),
        .B   (sh_b_q[0]),
        .Cin (carry_q),
        .S   (fa_s),
        .Cout(fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_s_d  = sh_s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = SHIFT;
                    sh_a_d  = bus.a;
                    sh_b_d  = bus.b;
                    sh_s_d  = '0;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Shift-and-insert written without a slice so WIDTH=1 elaborates.
                sh_s_d  = (sh_s_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = sh_s_d;
                    cout_d  = fa_cout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for arithmetic, timing and
// reset scenarios, and a 1-bit instance swept over the full-adder truth table.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Waits for the done pulse on the 8-bit instance, counting busy cycles and
    // recording the sum visible during the first busy cycle.
    task automatic wait_done8(output logic [7:0] s, output logic co, output int bc,
                              output logic [7:0] held, output bit to);
        bit first = 1'b1;
        bc = 0; to = 1'b1; s = '0; co = 1'b0; held = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if8.done) begin
                s = if8.sum; co = if8.cout; to = 1'b0;
                break;
            end
            if (if8.busy) begin
                if (first) held = if8.sum;
                first = 1'b0;
                bc++;
            end
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [7:0] s, output logic co, output int bc,
                       output logic [7:0] held, output bit to);
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
        @(posedge clk);
        #1 if8.start = 1'b0;
        wait_done8(s, co, bc, held, to);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        vectors += 4;
        if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", if8.busy); end
        if (if8.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", if8.done); end
        if (if8.sum !== 8'd0) begin miscompares++; $display("FAIL reset_sum got %0d want 0", if8.sum); end
        if (if8.cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout got %b want 0", if8.cout); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] s, held; logic co; int bc; bit to;
        op8(8'd100, 8'd27, 1'b0, s, co, bc, held, to);
        vectors += 5;
        if (to) begin miscompares++; $display("FAIL basic_timeout got no done want done"); end
        if (s !== 8'd127) begin miscompares++; $display("FAIL basic_sum got %0d want 127", s); end
        if (co !== 1'b0) begin miscompares++; $display("FAIL basic_cout got %b want 0", co); end
        if (bc != 8) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
        if (held !== 8'd0) begin miscompares++; $display("FAIL basic_sum_held got %0d want 0", held); end
    endtask

    task automatic test_carry;
        logic [7:0] s, held; logic co; int bc; bit to;
        op8(8'd255, 8'd1, 1'b0, s, co, bc, held, to);
        vectors += 4;
        if (to) begin miscompares++; $display("FAIL carry1_timeout got no done want done"); end
        if (s !== 8'd0) begin miscompares++; $display("FAIL carry1_sum got %0d want 0", s); end
        if (co !== 1'b1) begin miscompares++; $display("FAIL carry1_cout got %b want 1", co); end
        if (held !== 8'd127) begin miscompares++; $display("FAIL carry1_sum_held got %0d want 127", held); end
        op8(8'd255, 8'd255, 1'b1, s, co, bc, held, to);
        vectors += 4;
        if (to) begin miscompares++; $display("FAIL carry2_timeout got no done want done"); end
        if (s !== 8'd255) begin miscompares++; $display("FAIL carry2_sum got %0d want 255", s); end
        if (co !== 1'b1) begin miscompares++; $display("FAIL carry2_cout got %b want 1", co); end
        if (held !== 8'd0) begin miscompares++; $display("FAIL carry2_sum_held got %0d want 0", held); end
    endtask

    task automatic test_start_held;
        logic [7:0] s, held; logic co; int bc; bit to;
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd10; if8.b = 8'd5; if8.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.a = 8'd200; if8.b = 8'd100;
        wait_done8(s, co, bc, held, to);
        vectors += 4;
        if (to) begin miscompares++; $display("FAIL held_timeout got no done want done"); end
        if (s !== 8'd15) begin miscompares++; $display("FAIL held_sum got %0d want 15", s); end
        if (co !== 1'b0) begin miscompares++; $display("FAIL held_cout got %b want 0", co); end
        if (bc != 7) begin miscompares++; $display("FAIL held_busy_cycles got %0d want 7", bc); end
        // start still high in DONE: 200+100 is accepted on this edge
        @(posedge clk);
        #1 if8.start = 1'b0;
        @(negedge clk);
        vectors++;
        if (if8.busy !== 1'b1) begin miscompares++; $display("FAIL held_reaccept_busy got %b want 1", if8.busy); end
        wait_done8(s, co, bc, held, to);
        vectors += 3;
        if (to) begin miscompares++; $display("FAIL held2_timeout got no done want done"); end
        if (s !== 8'd44) begin miscompares++; $display("FAIL held2_sum got %0d want 44", s); end
        if (co !== 1'b1) begin miscompares++; $display("FAIL held2_cout got %b want 1", co); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] s, held; logic co; int bc; bit to;
        op8(8'd50, 8'd60, 1'b0, s, co, bc, held, to);
        vectors += 2;
        if (to) begin miscompares++; $display("FAIL b2b1_timeout got no done want done"); end
        if (s !== 8'd110) begin miscompares++; $display("FAIL b2b1_sum got %0d want 110", s); end
        if8.start = 1'b1; if8.a = 8'd7; if8.b = 8'd9; if8.cin = 1'b1;
        @(posedge clk);
        #1 if8.start = 1'b0;
        wait_done8(s, co, bc, held, to);
        vectors += 5;
        if (to) begin miscompares++; $display("FAIL b2b2_timeout got no done want done"); end
        if (bc != 8) begin miscompares++; $display("FAIL b2b2_busy_cycles got %0d want 8", bc); end
        if (held !== 8'd110) begin miscompares++; $display("FAIL b2b2_sum_held got %0d want 110", held); end
        if (s !== 8'd17) begin miscompares++; $display("FAIL b2b2_sum got %0d want 17", s); end
        if (co !== 1'b0) begin miscompares++; $display("FAIL b2b2_cout got %b want 0", co); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] s, held; logic co; int bc; bit to;
        int dones = 0;
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd255; if8.b = 8'd255; if8.cin = 1'b1;
        @(posedge clk);
        #1 if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors += 4;
        if (if8.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", if8.busy); end
        if (if8.done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b want 0", if8.done); end
        if (if8.sum !== 8'd0) begin miscompares++; $display("FAIL rstmid_sum got %0d want 0", if8.sum); end
        if (if8.cout !== 1'b0) begin miscompares++; $display("FAIL rstmid_cout got %b want 0", if8.cout); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) dones++;
        end
        vectors++;
        if (dones != 0) begin miscompares++; $display("FAIL rstmid_no_done got %0d pulses want 0", dones); end
        op8(8'd3, 8'd4, 1'b0, s, co, bc, held, to);
        vectors += 3;
        if (to) begin miscompares++; $display("FAIL rstmid_op_timeout got no done want done"); end
        if (s !== 8'd7) begin miscompares++; $display("FAIL rstmid_op_sum got %0d want 7", s); end
        if (co !== 1'b0) begin miscompares++; $display("FAIL rstmid_op_cout got %b want 0", co); end
    endtask

    task automatic test_width1;
        // indexed by {a,b,cin}: {cout,sum}
        logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            if1.start = 1'b1; if1.a = v[2]; if1.b = v[1]; if1.cin = v[0];
            @(posedge clk);
            #1 if1.start = 1'b0;
            @(negedge clk);
            vectors++;
            if (if1.busy !== 1'b1 || if1.done !== 1'b0) begin
                miscompares++;
                $display("FAIL w1_busy_%0d got busy=%b done=%b want busy=1 done=0", i, if1.busy, if1.done);
            end
            @(negedge clk);
            vectors += 2;
            if (if1.done !== 1'b1) begin miscompares++; $display("FAIL w1_done_%0d got %b want 1", i, if1.done); end
            if ({if1.cout, if1.sum} !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL w1_result_%0d got %b want %b", i, {if1.cout, if1.sum}, exp_tab[i]);
            end
        end
    endtask

    initial begin
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
